adc_boxcar_decimator: RTL and testbench
=======================================

Name: adc_boxcar_decimator

Overview:
- Downstream consumer of one LTC2195 channel word (16-bit signed sample, updated once per ADC conversion).
- Subtracts a programmable offset with saturation, then accumulates N = 2^LOG2N samples.
- Emits the block mean as a 16-bit signed word with a one-cycle valid strobe.
- The averaged stream feeds the AD9783 data inputs or readout logic, giving a low-noise, decimated monitor of the ADC.

Parameters:
- W, 16: sample and output width, two's complement.
- LOG2N, 4: log2 of block length; N = 16 samples per output. Legal range 1..8.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- enable_in  in  1  high = run; low = idle, and any partial block is discarded.
- clear_in  in  1  one-cycle synchronous flush of the partial block and pipeline.
- offset_in  in  W  signed offset subtracted from each sample. Sampled on the same cycle as data_in.
- data_in  in  W  signed ADC sample.
- valid_in  in  1  one-cycle strobe; data_in is valid on this cycle.
- data_out  out  W  signed block mean; holds its value between strobes.
- valid_out  out  1  one-cycle strobe marking a new data_out.
- sat_flag_out  out  1  sticky flag: an offset subtraction saturated.
- busy_out  out  1  high while in the ACCUM state.

Behaviour:
- Reset (rst_in = 1 at a clock edge):
  - data_out = 0, valid_out = 0, sat_flag_out = 0, busy_out = 0.
  - Accumulator = 0, sample count = 0, stage-1 register and its valid = 0, state = IDLE.
  - Reset overrides every other input, including a block completing mid-operation. No strobe is emitted.
- State machine:
  - IDLE: count = 0, accumulator = 0. Moves to ACCUM on the first cycle enable_in = 1. No sample is taken on that transition cycle.
  - ACCUM: stays while enable_in = 1. enable_in = 0 returns to IDLE on the next edge, discards the partial block and suppresses any pending strobe.
- Stage 1 (registered, ACCUM only, on valid_in):
  - d = data_in - offset_in, computed at W+1 bits.
  - Saturate d to [-2^(W-1), 2^(W-1)-1], i.e. [-32768, 32767] for W = 16.
  - If saturation occurs, set sat_flag_out on the same edge that registers d.
- Stage 2 (accumulate):
  - When stage-1 valid: acc <= acc + d_sat, count <= count + 1.
  - Accumulator width is W + LOG2N, so it never overflows.
- Block completion, when stage-1 valid and count = N-1:
  - data_out <= (acc + d_sat) >>> LOG2N. Arithmetic shift, truncating toward minus infinity.
  - valid_out pulses for one cycle.
  - acc <= 0, count <= 0, on the same edge.
- Latency: valid_out is high exactly 2 clk_in cycles after the valid_in that carried the Nth sample.
- Throughput:
  - valid_in may be asserted on consecutive cycles; no sample is dropped and no backpressure exists.
  - Back-to-back blocks produce strobes spaced exactly N cycles apart.
- clear_in:
  - acc = 0, count = 0, stage-1 valid dropped, sat_flag_out = 0.
  - data_out holds; valid_out is 0 on the following cycle.
  - clear_in together with valid_in: clear wins, and that sample is discarded.
  - clear_in on a completion cycle: the strobe is suppressed.
- sat_flag_out is cleared only by rst_in or clear_in. enable_in = 0 does not clear it.
- Wrap-around: the count wraps N-1 -> 0 only through block completion. No other wrap exists.

Test Plan (LOG2N = 2, N = 4 unless stated):
- Reset, enable, then 4 consecutive valid_in with data 100, 200, 300, 401 and offset 0 -> valid_out 2 cycles after the 4th sample, data_out = 250 (1001 >>> 2). Strobe lasts one cycle.
- Data -3, -3, -3, -2, offset 0 -> data_out = -3, confirming truncation toward minus infinity.
- data_in = -32768 with offset_in = 1 on all 4 samples -> each difference saturates to -32768, data_out = -32768, sat_flag_out = 1 and stays 1 until clear_in.
- 2 samples, then clear_in asserted together with a 3rd valid_in, then 4 samples of 40 -> exactly one strobe, data_out = 40.
- Continuous valid_in for 12 cycles with data = 1000 -> three strobes, 4 cycles apart, each data_out = 1000.
- rst_in asserted on the cycle the 4th sample enters stage 2 -> no strobe, all outputs 0. Then enable again, 4 samples of 7 -> data_out = 7.

Source files
------------

// File: rtl/adc_boxcar_decimator.sv
// -----------------------------------------------------------------------------
// adc_boxcar_decimator
//
// Boxcar averager / decimator for one LTC2195 channel word. Each accepted
// sample has a programmable offset removed (with saturation to the W-bit
// range). The result is accumulated over N = 2^LOG2N samples, and the block
// mean is emitted as a W-bit signed word with a one-cycle strobe.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_in        synchronous active-high reset
//   enable_in     1 = run, 0 = idle (any partial block is discarded)
//   clear_in      one-cycle flush of the partial block, the pipeline and sat flag
//   offset_in     signed offset subtracted from data_in (same cycle)
//   data_in       signed ADC sample
//   valid_in      data_in is valid on this cycle
//   data_out      signed block mean, held between strobes
//   valid_out     one-cycle strobe marking a new data_out
//   sat_flag_out  sticky: an offset subtraction saturated
//   busy_out      high while in the ACCUM state
//
// Pipeline: stage 1 registers the saturated difference. Stage 2 accumulates
// it and, on the Nth sample, registers the mean. valid_out therefore rises
// two clocks after the valid_in that carried the Nth sample.
// -----------------------------------------------------------------------------
module adc_boxcar_decimator #(
    parameter int W     = 16,
    parameter int LOG2N = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    input  logic                clear_in,
    input  logic signed [W-1:0] offset_in,
    input  logic signed [W-1:0] data_in,
    input  logic                valid_in,
    output logic signed [W-1:0] data_out,
    output logic                valid_out,
    output logic                sat_flag_out,
    output logic                busy_out
);

    localparam int ACCW = W + LOG2N;
    localparam logic [W-1:0]     SAMPLE_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAMPLE_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [LOG2N-1:0] COUNT_LAST = {LOG2N{1'b1}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state_reg, state_next;
    logic   run;

    // ---------------- state machine ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // run is only asserted in ACCUM while enable_in is still high. The
    // IDLE->ACCUM transition cycle therefore takes no sample. Dropping enable
    // in ACCUM discards the pipeline on that same edge.
    always_comb begin
        state_next = state_reg;
        busy_out   = 1'b0;
        run        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_in) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                busy_out = 1'b1;
                run      = enable_in;
                if (!enable_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- stage 1: offset subtraction with saturation ----------------
    logic [W:0]   diff;
    logic         diff_ovf;
    logic [W-1:0] diff_sat;
    logic         take;

    always_comb begin
        diff     = {data_in[W-1], data_in} - {offset_in[W-1], offset_in};
        // The top two bits differ exactly when the result leaves the W-bit range.
        diff_ovf = diff[W] ^ diff[W-1];
        if (diff_ovf) begin
            diff_sat = diff[W] ? SAMPLE_MIN : SAMPLE_MAX;
        end else begin
            diff_sat = diff[W-1:0];
        end
        take = run && valid_in && !clear_in;
    end

    logic [W-1:0] s1_data_reg;
    logic         s1_valid_reg;
    logic         sat_flag_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
        end else begin
            s1_valid_reg <= take;
            if (take) begin
                s1_data_reg <= diff_sat;
            end
            if (clear_in) begin
                sat_flag_reg <= 1'b0;
            end else if (take && diff_ovf) begin
                sat_flag_reg <= 1'b1;
            end
        end
    end

    // ---------------- stage 2: accumulate and emit the block mean ----------------
    logic [ACCW-1:0]  acc_reg;
    logic [ACCW-1:0]  acc_next;
    logic [LOG2N-1:0] count_reg;
    logic [W-1:0]     data_out_reg;
    logic             valid_out_reg;
    logic             last_sample;

    always_comb begin
        acc_next    = acc_reg + {{LOG2N{s1_data_reg[W-1]}}, s1_data_reg};
        last_sample = (count_reg == COUNT_LAST);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            if (clear_in || !run) begin
                // Flush, or idle/leaving ACCUM: drop the partial block and
                // any strobe it was about to produce.
                acc_reg   <= '0;
                count_reg <= '0;
            end else if (s1_valid_reg) begin
                if (last_sample) begin
                    // Taking the upper W bits is an arithmetic shift right by
                    // LOG2N, i.e. the mean rounded toward minus infinity.
                    data_out_reg  <= acc_next[ACCW-1:LOG2N];
                    valid_out_reg <= 1'b1;
                    acc_reg       <= '0;
                    count_reg     <= '0;
                end else begin
                    acc_reg   <= acc_next;
                    count_reg <= count_reg + LOG2N'(1);
                end
            end
        end
    end

    assign data_out     = data_out_reg;
    assign valid_out    = valid_out_reg;
    assign sat_flag_out = sat_flag_reg;

endmodule

// File: tb/tb_adc_boxcar_decimator.sv
module tb_adc_boxcar_decimator;

    localparam int W     = 16;
    localparam int LOG2N = 2;
    localparam int N     = 4;

    logic                clk = 1'b0;
    logic                rst_in;
    logic                enable_in;
    logic                clear_in;
    logic signed [W-1:0] offset_in;
    logic signed [W-1:0] data_in;
    logic                valid_in;
    logic signed [W-1:0] data_out;
    logic                valid_out;
    logic                sat_flag_out;
    logic                busy_out;

    adc_boxcar_decimator #(.W(W), .LOG2N(LOG2N)) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .enable_in    (enable_in),
        .clear_in     (clear_in),
        .offset_in    (offset_in),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .sat_flag_out (sat_flag_out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   m_sum      = 0;
    int   m_cnt      = 0;
    logic sat_exp    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic model_flush();
        m_sum = 0;
        m_cnt = 0;
    endtask

    // Drive one valid sample and update the reference model.
    task automatic send(input int d, input int o);
        int r;
        r = d - o;
        if (r > 32767) begin
            r = 32767;
            sat_exp = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat_exp = 1'b1;
        end
        data_in   = W'(d);
        offset_in = W'(o);
        valid_in  = 1'b1;
        m_sum += r;
        m_cnt++;
        if (m_cnt == N) begin
            sb.push_back('{data: (m_sum >>> LOG2N), cyc: cyc + 2});
            model_flush();
        end
        tick();
        valid_in = 1'b0;
    endtask

    // Output monitor: every strobe must match the oldest expected block.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("strobe cyc=%0d data_out=%0d (expected %0d at cyc %0d)",
                         cyc, data_out, e.data, e.cyc);
                check("strobe_data", data_out, e.data);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in    = 1'b1;
        enable_in = 1'b0;
        clear_in  = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        offset_in = '0;
        repeat (3) tick();
        check("rst_data_out", data_out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_sat_flag", sat_flag_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b0;

        enable_in = 1'b1;
        tick();
        check("busy_after_enable", busy_out, 1);

        // Basic mean: 1001 >>> 2 = 250
        send(100, 0); send(200, 0); send(300, 0); send(401, 0);
        idle(4);
        check("hold_250", data_out, 250);
        check("sat_clear_1", sat_flag_out, sat_exp);

        // Truncation toward minus infinity: -11 >>> 2 = -3
        send(-3, 0); send(-3, 0); send(-3, 0); send(-2, 0);
        idle(4);
        check("hold_neg3", data_out, -3);

        // Negative saturation
        repeat (4) send(-32768, 1);
        idle(4);
        check("sat_set", sat_flag_out, sat_exp);

        // enable low: back to IDLE, sat flag must survive
        enable_in = 1'b0;
        model_flush();
        tick();
        check("busy_disabled", busy_out, 0);
        check("sat_kept_disabled", sat_flag_out, sat_exp);
        enable_in = 1'b1;
        tick();
        check("busy_reenabled", busy_out, 1);

        // Partial block, then clear together with a sample
        send(5, 0); send(6, 0);
        clear_in  = 1'b1;
        valid_in  = 1'b1;
        data_in   = 16'sd999;
        offset_in = '0;
        model_flush();
        sat_exp = 1'b0;
        tick();
        clear_in = 1'b0;
        valid_in = 1'b0;
        check("sat_after_clear", sat_flag_out, sat_exp);
        check("hold_after_clear", data_out, -32768);
        repeat (4) send(40, 0);
        idle(4);
        check("hold_40", data_out, 40);

        // Continuous stream: three back-to-back blocks
        repeat (12) send(1000, 0);
        idle(4);
        check("hold_1000", data_out, 1000);

        // Reset on the completion edge of a block
        send(11, 0); send(12, 0); send(13, 0); send(14, 0);
        rst_in = 1'b1;
        sb.delete();
        model_flush();
        sat_exp = 1'b0;
        tick();
        check("midrst_data_out", data_out, 0);
        check("midrst_valid_out", valid_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_sat", sat_flag_out, 0);
        rst_in = 1'b0;
        tick();
        check("busy_after_rst", busy_out, 1);
        repeat (4) send(7, 0);
        idle(4);
        check("hold_7", data_out, 7);

        idle(6);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
